// File: rtl/maquina_lectura.sv
// maquina_lectura: RTC read sequencer. It sends the clock-to-RAM transfer command, reads the
// clock and (optionally) timer registers, then publishes every value on one edge.
module maquina_lectura #(
    parameter bit         LEER_TIMER = 1'b1,
    parameter logic [7:0] CMD_TRANSF = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Lectura,
    input  logic       DIR,
    input  logic       DAT,
    input  logic       cambio_estado,
    input  logic [7:0] Dato_in,
    output logic [7:0] Dato_Dire,
    output logic       E_lec,
    output logic       Wr_Rd,
    output logic       Term_Lec,
    output logic [7:0] Seg,
    output logic [7:0] Min,
    output logic [7:0] Hora,
    output logic [7:0] Dia,
    output logic [7:0] Mes,
    output logic [7:0] Ano,
    output logic [7:0] T_Seg,
    output logic [7:0] T_Min,
    output logic [7:0] T_Hora
);
    typedef enum logic [3:0] {
        IDLE, CMD, R_SEG, R_MIN, R_HORA, R_DIA, R_MES, R_ANO, R_TSEG, R_TMIN, R_THORA
    } t_estado;

    t_estado          r_estado, w_sig;
    logic             r_e_lec, r_wr_rd, w_avanza, w_fin;
    logic [7:0]       r_dato_dire, w_dire;
    logic [3:0]       w_idx;
    logic [8:0][7:0]  r_sh, r_val;

    // Read states map linearly onto 0x21..0x26 and 0x41..0x43
    always_comb begin
        w_sig    = r_estado;
        w_fin    = 1'b0;
        w_idx    = r_estado - 4'd2;
        w_avanza = !DIR && !DAT && cambio_estado;
        w_dire   = (r_estado == CMD) ? CMD_TRANSF :
                   (r_estado >= R_TSEG) ? 8'h39 + {4'h0, r_estado} : 8'h1F + {4'h0, r_estado};
        if (r_estado == IDLE) begin
            w_sig = Lectura ? CMD : IDLE;
        end else if (w_avanza) begin
            w_fin = (r_estado == R_THORA) || (r_estado == R_ANO && !LEER_TIMER);
            w_sig = w_fin ? IDLE : t_estado'(r_estado + 4'd1);
        end
        Term_Lec = w_fin && reset;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado    <= IDLE;
            r_e_lec     <= 1'b0;
            r_wr_rd     <= 1'b0;
            r_dato_dire <= 8'h00;
            r_sh        <= '0;
            r_val       <= '0;
        end else begin
            r_estado <= w_sig;
            r_wr_rd  <= (w_sig == CMD);
            if (r_estado == IDLE)
                r_e_lec <= Lectura;
            else if (DIR)
                r_dato_dire <= w_dire;
            else if (DAT) begin
                if (r_estado == CMD)
                    r_dato_dire <= 8'h00;
                else
                    r_sh[w_idx] <= Dato_in;
            end else
                r_e_lec <= !cambio_estado;
            if (w_fin)
                r_val <= LEER_TIMER ? r_sh : {r_val[8:6], r_sh[5:0]};
        end
    end

    assign Dato_Dire = r_dato_dire;
    assign E_lec     = r_e_lec;
    assign Wr_Rd     = r_wr_rd;
    assign Seg       = r_val[0];
    assign Min       = r_val[1];
    assign Hora      = r_val[2];
    assign Dia       = r_val[3];
    assign Mes       = r_val[4];
    assign Ano       = r_val[5];
    assign T_Seg     = r_val[6];
    assign T_Min     = r_val[7];
    assign T_Hora    = r_val[8];
endmodule

// File: tb/tb_maquina_lectura.sv
// tb_maquina_lectura: directed bench for maquina_lectura with and without timer reads.
// The bench plays the bus-timing generator; inputs change and outputs are sampled on negedge.
module tb_maquina_lectura;
    logic       clk = 1'b0, reset = 1'b0, lect1 = 1'b0, lect0 = 1'b0;
    logic       DIR = 1'b0, DAT = 1'b0, cambio = 1'b0, sel = 1'b1;
    logic [7:0] din = 8'h00, hold_seg = 8'h00;
    logic [7:0] dd1, dd0, v1 [9], v0 [9], o_v [9];
    logic       el1, el0, wr1, wr0, t1, t0;
    int         chk_n = 0, err_n = 0, tc1 = 0, tc0 = 0, tc_prev;

    always #5 clk = ~clk;

    maquina_lectura #(.LEER_TIMER(1'b1), .CMD_TRANSF(8'hF0)) dut1 (
        .clk(clk), .reset(reset), .Lectura(lect1), .DIR(DIR), .DAT(DAT), .cambio_estado(cambio),
        .Dato_in(din), .Dato_Dire(dd1), .E_lec(el1), .Wr_Rd(wr1), .Term_Lec(t1),
        .Seg(v1[0]), .Min(v1[1]), .Hora(v1[2]), .Dia(v1[3]), .Mes(v1[4]), .Ano(v1[5]),
        .T_Seg(v1[6]), .T_Min(v1[7]), .T_Hora(v1[8]));

    maquina_lectura #(.LEER_TIMER(1'b0), .CMD_TRANSF(8'hF0)) dut0 (
        .clk(clk), .reset(reset), .Lectura(lect0), .DIR(DIR), .DAT(DAT), .cambio_estado(cambio),
        .Dato_in(din), .Dato_Dire(dd0), .E_lec(el0), .Wr_Rd(wr0), .Term_Lec(t0),
        .Seg(v0[0]), .Min(v0[1]), .Hora(v0[2]), .Dia(v0[3]), .Mes(v0[4]), .Ano(v0[5]),
        .T_Seg(v0[6]), .T_Min(v0[7]), .T_Hora(v0[8]));

    wire [7:0] o_dd   = sel ? dd1 : dd0;
    wire       o_el   = sel ? el1 : el0;
    wire       o_wr   = sel ? wr1 : wr0;
    wire       o_term = sel ? t1 : t0;

    always_comb for (int i = 0; i < 9; i++) o_v[i] = sel ? v1[i] : v0[i];

    always @(posedge clk) begin
        if (t1) tc1 <= tc1 + 1;
        if (t0) tc0 <= tc0 + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_n++;
        assert (obs === exp) else begin
            err_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic [71:0] e);
        for (int i = 0; i < 9; i++) chk($sformatf("out%0d", i), o_v[i], e[8*(8-i) +: 8]);
    endtask

    task automatic start();
        chk("idle_elec", o_el, 8'd0);
        if (sel) lect1 = 1'b1; else lect0 = 1'b1;
        @(negedge clk);
        lect1 = 1'b0;
        lect0 = 1'b0;
        chk("latency_elec", o_el, 8'd1);
    endtask

    // mode 0: plain; 1: DIR+DAT(pre) around the real DAT; 2: DAT(pre) then DAT(d); 3: no DAT
    task automatic trans(input logic [7:0] addr, input logic wr, input logic [7:0] d,
                         input int mode, input logic [7:0] pre, input logic last);
        for (int n = 0; n < 20 && !o_el; n++) @(negedge clk);
        chk("elec_up", o_el, 8'd1);
        DIR = 1'b1;
        @(negedge clk);
        DIR = 1'b0;
        chk("addr", o_dd, addr);
        chk("wr_rd", o_wr, wr);
        chk("hold_seg", o_v[0], hold_seg);
        if (mode == 1) begin
            DIR = 1'b1; DAT = 1'b1; din = pre;
            @(negedge clk);
            DIR = 1'b0; DAT = 1'b0;
            chk("dirdat_addr", o_dd, addr);
        end
        if (mode == 2) begin
            DAT = 1'b1; din = pre;
            @(negedge clk);
        end
        if (mode != 3) begin
            DAT = 1'b1; din = d;
            @(negedge clk);
            DAT = 1'b0;
            if (wr) chk("cmd_data", o_dd, 8'h00);
        end
        if (mode == 1) begin
            DIR = 1'b1; DAT = 1'b1; din = pre;
            @(negedge clk);
            DIR = 1'b0; DAT = 1'b0;
        end
        cambio = 1'b1;
        #1 chk("term", o_term, {7'd0, last});
        @(negedge clk);
        cambio = 1'b0;
        chk("elec_gap", o_el, 8'd0);
        @(negedge clk);
        chk("elec_back", o_el, {7'd0, !last});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all(72'h0);
        chk("rst_elec", el1, 8'd0);
        chk("rst_dd", dd1, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wr", wr1, 8'd0);
        chk("rst_term", t1, 8'd0);

        // Full sequence with timer reads; Lectura in R_DIA must be ignored
        sel = 1'b1;
        hold_seg = 8'h00;
        start();
        trans(8'hF0, 1'b1, 8'hEE, 0, 8'h00, 1'b0);
        trans(8'h21, 1'b0, 8'h45, 0, 8'h00, 1'b0);
        trans(8'h22, 1'b0, 8'h30, 0, 8'h00, 1'b0);
        trans(8'h23, 1'b0, 8'h12, 0, 8'h00, 1'b0);
        lect1 = 1'b1;
        @(negedge clk);
        lect1 = 1'b0;
        trans(8'h24, 1'b0, 8'h15, 0, 8'h00, 1'b0);
        trans(8'h25, 1'b0, 8'h09, 0, 8'h00, 1'b0);
        trans(8'h26, 1'b0, 8'h16, 0, 8'h00, 1'b0);
        trans(8'h41, 1'b0, 8'h10, 0, 8'h00, 1'b0);
        trans(8'h42, 1'b0, 8'h05, 0, 8'h00, 1'b0);
        check_all(72'h0);
        trans(8'h43, 1'b0, 8'h00, 0, 8'h00, 1'b1);
        check_all(72'h45_30_12_15_09_16_10_05_00);
        chk("term_count_a", tc1[7:0], 8'd1);

        // DIR+DAT collision in R_SEG, double DAT in R_HORA
        hold_seg = 8'h45;
        start();
        trans(8'hF0, 1'b1, 8'h00, 0, 8'h00, 1'b0);
        trans(8'h21, 1'b0, 8'h59, 1, 8'hAA, 1'b0);
        trans(8'h22, 1'b0, 8'h01, 0, 8'h00, 1'b0);
        trans(8'h23, 1'b0, 8'h22, 2, 8'h11, 1'b0);
        trans(8'h24, 1'b0, 8'h02, 0, 8'h00, 1'b0);
        trans(8'h25, 1'b0, 8'h03, 0, 8'h00, 1'b0);
        trans(8'h26, 1'b0, 8'h04, 0, 8'h00, 1'b0);
        trans(8'h41, 1'b0, 8'h05, 0, 8'h00, 1'b0);
        trans(8'h42, 1'b0, 8'h06, 0, 8'h00, 1'b0);
        trans(8'h43, 1'b0, 8'h07, 0, 8'h00, 1'b1);
        check_all(72'h59_01_22_02_03_04_05_06_07);
        chk("term_count_b", tc1[7:0], 8'd2);

        // Reset for two cycles in the middle of R_MIN
        hold_seg = 8'h59;
        start();
        trans(8'hF0, 1'b1, 8'h00, 0, 8'h00, 1'b0);
        trans(8'h21, 1'b0, 8'h77, 0, 8'h00, 1'b0);
        DIR = 1'b1;
        @(negedge clk);
        DIR = 1'b0; DAT = 1'b1; din = 8'h88;
        @(negedge clk);
        DAT = 1'b0;
        tc_prev = tc1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_term", t1, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        check_all(72'h0);
        chk("rst_mid_elec", el1, 8'd0);
        chk("rst_mid_dd", dd1, 8'h00);
        chk("rst_mid_wr", wr1, 8'd0);
        chk("rst_mid_tc", tc1[7:0], tc_prev[7:0]);
        @(negedge clk);
        chk("rst_mid_idle", el1, 8'd0);

        // No DAT in R_SEG: the discarded 0x77 must not reappear
        hold_seg = 8'h00;
        start();
        trans(8'hF0, 1'b1, 8'h00, 0, 8'h00, 1'b0);
        trans(8'h21, 1'b0, 8'h00, 3, 8'h00, 1'b0);
        trans(8'h22, 1'b0, 8'h32, 0, 8'h00, 1'b0);
        trans(8'h23, 1'b0, 8'h33, 0, 8'h00, 1'b0);
        trans(8'h24, 1'b0, 8'h34, 0, 8'h00, 1'b0);
        trans(8'h25, 1'b0, 8'h35, 0, 8'h00, 1'b0);
        trans(8'h26, 1'b0, 8'h36, 0, 8'h00, 1'b0);
        trans(8'h41, 1'b0, 8'h37, 0, 8'h00, 1'b0);
        trans(8'h42, 1'b0, 8'h38, 0, 8'h00, 1'b0);
        trans(8'h43, 1'b0, 8'h39, 0, 8'h00, 1'b1);
        check_all(72'h00_32_33_34_35_36_37_38_39);
        tc_prev = tc1;

        // Timer reads disabled: seven transactions, timer outputs untouched
        sel = 1'b0;
        hold_seg = 8'h00;
        start();
        trans(8'hF0, 1'b1, 8'h00, 0, 8'h00, 1'b0);
        trans(8'h21, 1'b0, 8'h50, 0, 8'h00, 1'b0);
        trans(8'h22, 1'b0, 8'h51, 0, 8'h00, 1'b0);
        trans(8'h23, 1'b0, 8'h52, 0, 8'h00, 1'b0);
        trans(8'h24, 1'b0, 8'h53, 0, 8'h00, 1'b0);
        trans(8'h25, 1'b0, 8'h54, 0, 8'h00, 1'b0);
        trans(8'h26, 1'b0, 8'h55, 0, 8'h00, 1'b1);
        check_all(72'h50_51_52_53_54_55_00_00_00);
        chk("term_count_0", tc0[7:0], 8'd1);
        repeat (3) @(negedge clk);
        chk("idle_after_0", el0, 8'd0);
        chk("tc1_untouched", tc1[7:0], tc_prev[7:0]);

        $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
        $finish;
    end
endmodule
